// File: rtl/ring_interlock_ctrl.sv
// Interlock controller for a ring of contactors: arbitrates close requests
// against forbidden closed-set rules, debounces feedback, supervises each coil.
module ring_interlock_ctrl #(
  parameter int N_CONTACTORS = 8,
  parameter int N_RULES      = 7,
  parameter logic [N_RULES*N_CONTACTORS-1:0] RULES = 56'h9B_6B_C6_96_E6_1B_07,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FB_TIMEOUT      = 1000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N_CONTACTORS-1:0] i_req,
  input  logic [N_CONTACTORS-1:0] i_fb,
  input  logic                    i_fault_clr,
  output logic [N_CONTACTORS-1:0] o_close,
  output logic [N_CONTACTORS-1:0] o_fault,
  output logic [N_CONTACTORS-1:0] o_denied,
  output logic                    o_trip
);

  localparam int TW = $clog2(FB_TIMEOUT + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(FB_TIMEOUT - 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_OPEN,
    ST_CLOSING,
    ST_CLOSED,
    ST_OPENING,
    ST_FAULT
  } state_t;

  state_t                  state_q  [N_CONTACTORS];
  state_t                  state_d  [N_CONTACTORS];
  logic [TW-1:0]           tmr_q    [N_CONTACTORS];
  logic [TW-1:0]           tmr_d    [N_CONTACTORS];
  logic [DW-1:0]           db_cnt_q [N_CONTACTORS];
  logic [DW-1:0]           db_cnt_d [N_CONTACTORS];
  logic [N_CONTACTORS-1:0] fb_db_q, fb_db_d;
  logic [N_CONTACTORS-1:0] committed, cand, permit, grant;
  logic [N_CONTACTORS-1:0] close_d, fault_d, denied_d;
  logic                    forbidden_now, trip_act, trip_d;

  function automatic logic rule_hit(input logic [N_CONTACTORS-1:0] s);
    logic                    hit;
    logic [N_CONTACTORS-1:0] m;
    hit = 1'b0;
    for (int unsigned r = 0; r < N_RULES; r++) begin
      m = RULES[r*N_CONTACTORS +: N_CONTACTORS];
      if (m != '0 && (s & m) == m) hit = 1'b1;
    end
    return hit;
  endfunction

  // Feedback debounce: accept a new level after DEBOUNCE_CYCLES differing samples.
  always_comb begin
    fb_db_d = fb_db_q;
    for (int unsigned i = 0; i < N_CONTACTORS; i++) begin
      db_cnt_d[i] = '0;
      if (i_fb[i] != fb_db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) fb_db_d[i] = i_fb[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  // Arbitration: single lowest-index grant among permitted candidates.
  always_comb begin
    logic                    found;
    logic [N_CONTACTORS-1:0] onehot;
    committed = '0;
    cand      = '0;
    permit    = '0;
    grant     = '0;
    found     = 1'b0;
    forbidden_now = rule_hit(fb_db_q);
    trip_act      = o_trip | forbidden_now;
    for (int unsigned i = 0; i < N_CONTACTORS; i++) begin
      committed[i] = (state_q[i] == ST_CLOSING) || (state_q[i] == ST_CLOSED) || fb_db_q[i];
    end
    for (int unsigned i = 0; i < N_CONTACTORS; i++) begin
      onehot    = '0;
      onehot[i] = 1'b1;
      cand[i]   = (state_q[i] == ST_OPEN) && i_req[i];
      permit[i] = !rule_hit(committed | onehot);
      if (cand[i] && permit[i] && !found && !trip_act) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    denied_d = cand & ~permit;
    trip_d   = forbidden_now | (o_trip & ~i_fault_clr);
  end

  // Per-channel supervision; the timer is held at zero except while waiting in
  // CLOSING/OPENING, which gives clear-on-entry for free.
  always_comb begin
    close_d = '0;
    fault_d = '0;
    for (int unsigned i = 0; i < N_CONTACTORS; i++) begin
      state_d[i] = state_q[i];
      tmr_d[i]   = '0;
      case (state_q[i])
        ST_OPEN: begin
          if (fb_db_q[i])    state_d[i] = ST_FAULT;
          else if (grant[i]) state_d[i] = ST_CLOSING;
        end
        ST_CLOSING: begin
          if (!fb_db_q[i] && tmr_q[i] == TMR_LAST) state_d[i] = ST_FAULT;
          else if (!i_req[i] || trip_act)          state_d[i] = ST_OPENING;
          else if (fb_db_q[i])                     state_d[i] = ST_CLOSED;
          else                                     tmr_d[i]   = tmr_q[i] + 1'b1;
        end
        ST_CLOSED: begin
          if (!fb_db_q[i])                 state_d[i] = ST_FAULT;
          else if (!i_req[i] || trip_act)  state_d[i] = ST_OPENING;
        end
        ST_OPENING: begin
          if (!fb_db_q[i])              state_d[i] = ST_OPEN;
          else if (tmr_q[i] == TMR_LAST) state_d[i] = ST_FAULT;
          else                          tmr_d[i]   = tmr_q[i] + 1'b1;
        end
        ST_FAULT: begin
          if (i_fault_clr && !i_req[i] && !fb_db_q[i]) state_d[i] = ST_OPEN;
        end
        default: state_d[i] = ST_FAULT;
      endcase
      close_d[i] = ((state_d[i] == ST_CLOSING) || (state_d[i] == ST_CLOSED)) && !trip_d;
      fault_d[i] = (state_d[i] == ST_FAULT);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= '{default: ST_OPEN};
      tmr_q    <= '{default: '0};
      db_cnt_q <= '{default: '0};
      fb_db_q  <= '0;
      o_close  <= '0;
      o_fault  <= '0;
      o_denied <= '0;
      o_trip   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      db_cnt_q <= db_cnt_d;
      fb_db_q  <= fb_db_d;
      o_close  <= close_d;
      o_fault  <= fault_d;
      o_denied <= denied_d;
      o_trip   <= trip_d;
    end
  end

endmodule

// File: tb/tb_ring_interlock_ctrl.sv
// Bench for ring_interlock_ctrl: directed scenarios followed by random traffic,
// all outputs compared every cycle against a behavioural reference model.
module tb_ring_interlock_ctrl;

  localparam int N  = 8;
  localparam int NR = 7;
  localparam logic [55:0] RULES = 56'h9B_6B_C6_96_E6_1B_07;
  localparam int DEB = 4;
  localparam int TO  = 1000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req, fb;
  logic         clr;
  logic [N-1:0] o_close, o_fault, o_denied;
  logic         o_trip;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  ring_interlock_ctrl #(
    .N_CONTACTORS(N), .N_RULES(NR), .RULES(RULES),
    .DEBOUNCE_CYCLES(DEB), .FB_TIMEOUT(TO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_fb(fb), .i_fault_clr(clr),
    .o_close(o_close), .o_fault(o_fault), .o_denied(o_denied), .o_trip(o_trip)
  );

  always #5 clk = ~clk;

  // Reference model: channel mode letters, age counters, filtered feedback.
  localparam byte M_OPEN = "o", M_CLOSING = "c", M_CLOSED = "k", M_OPENING = "p", M_FAULT = "f";
  byte          m_mode [N];
  int           m_age  [N];
  int           m_run  [N];
  logic [N-1:0] m_fb, m_close, m_fault, m_denied;
  logic         m_trip;

  function automatic bit forbidden(input logic [N-1:0] s);
    logic [55:0]  tbl;
    logic [N-1:0] m;
    tbl = RULES;
    for (int r = 0; r < NR; r++) begin
      m = tbl[r*N +: N];
      if (m != 0 && (s & m) == m) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_step();
    logic [N-1:0] held, nfb;
    byte          nm [N];
    bit           blocked, nt;
    int           winner;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin m_mode[i] = M_OPEN; m_age[i] = 0; m_run[i] = 0; end
      m_fb = 0; m_close = 0; m_fault = 0; m_denied = 0; m_trip = 0;
      return;
    end
    held = m_fb;
    for (int i = 0; i < N; i++)
      if (m_mode[i] == M_CLOSING || m_mode[i] == M_CLOSED) held[i] = 1'b1;
    blocked = m_trip || forbidden(m_fb);
    winner = -1;
    m_denied = 0;
    for (int i = 0; i < N; i++) begin
      if (m_mode[i] == M_OPEN && req[i]) begin
        if (forbidden(held | (N'(1) << i))) m_denied[i] = 1'b1;
        else if (winner < 0 && !blocked) winner = i;
      end
    end
    for (int i = 0; i < N; i++) begin
      nm[i] = m_mode[i];
      case (m_mode[i])
        M_OPEN:    if (m_fb[i]) nm[i] = M_FAULT; else if (winner == i) nm[i] = M_CLOSING;
        M_CLOSING: if (!m_fb[i] && m_age[i] + 1 >= TO) nm[i] = M_FAULT;
                   else if (!req[i] || blocked) nm[i] = M_OPENING;
                   else if (m_fb[i]) nm[i] = M_CLOSED;
        M_CLOSED:  if (!m_fb[i]) nm[i] = M_FAULT; else if (!req[i] || blocked) nm[i] = M_OPENING;
        M_OPENING: if (!m_fb[i]) nm[i] = M_OPEN; else if (m_age[i] + 1 >= TO) nm[i] = M_FAULT;
        default:   if (clr && !req[i] && !m_fb[i]) nm[i] = M_OPEN;
      endcase
      m_age[i] = (nm[i] == m_mode[i]) ? m_age[i] + 1 : 0;
    end
    nfb = m_fb;
    for (int i = 0; i < N; i++) begin
      if (fb[i] == m_fb[i]) m_run[i] = 0;
      else begin
        m_run[i]++;
        if (m_run[i] == DEB) begin nfb[i] = fb[i]; m_run[i] = 0; end
      end
    end
    nt = forbidden(m_fb) || (m_trip && !clr);
    for (int i = 0; i < N; i++) begin
      m_mode[i]  = nm[i];
      m_close[i] = (nm[i] == M_CLOSING || nm[i] == M_CLOSED) && !nt;
      m_fault[i] = (nm[i] == M_FAULT);
    end
    m_fb   = nfb;
    m_trip = nt;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at cycle %0d: observed %h, expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    check("close",  32'(o_close),  32'(m_close));
    check("fault",  32'(o_fault),  32'(m_fault));
    check("denied", 32'(o_denied), 32'(m_denied));
    check("trip",   32'(o_trip),   32'(m_trip));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; fb = '0; clr = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; req = 8'hFF; fb = '0; clr = 1'b0;
    for (int i = 0; i < N; i++) begin m_mode[i] = M_OPEN; m_age[i] = 0; m_run[i] = 0; end
    m_fb = 0; m_close = 0; m_fault = 0; m_denied = 0; m_trip = 0;

    // reset with every request asserted, then one grant per cycle
    repeat (3) tick();
    check("rst_outputs", {o_close, o_fault, o_denied, 7'b0, o_trip}, 32'h0);
    rst_n = 1'b1;
    tick(); check("seq_ch0", 32'(o_close), 32'h01);
    tick(); check("seq_ch1", 32'(o_close), 32'h03);
    tick(); check("seq_block_c_close", 32'(o_close), 32'h0B);
    check("seq_block_c_denied", 32'(o_denied[2]), 32'h1);

    // rule block on C while A and B are closed
    do_reset();
    req = 8'h03;
    tick(); tick();
    fb = 8'h03;
    repeat (5) tick();
    req = 8'h07;
    tick(); check("ruleblk_denied", 32'(o_denied[2]), 32'h1);
    check("ruleblk_close", 32'(o_close[2]), 32'h0);
    req = 8'h06;
    tick(); check("ruleblk_a_open", 32'(o_close[0]), 32'h0);
    fb = 8'h02;
    n = 0;
    while (!o_close[2] && n < 20) begin tick(); n++; end
    check("ruleblk_grant_lat", 32'(n), 32'd5);

    // feedback timeout on channel 3
    do_reset();
    req = 8'h08;
    tick(); check("to_close", 32'(o_close[3]), 32'h1);
    n = 0;
    while (!o_fault[3] && n < TO + 100) begin tick(); n++; end
    check("to_latency", 32'(n), 32'(TO));
    req = '0; clr = 1'b1;
    tick(); check("to_cleared", 32'(o_fault[3]), 32'h0);
    clr = 1'b0;

    // debounce: short glitch ignored, full-length closure faults
    do_reset();
    fb = 8'h02; repeat (DEB - 1) tick();
    fb = 8'h00; repeat (3) tick();
    check("deb_glitch", 32'(o_fault[1]), 32'h0);
    fb = 8'h02; repeat (DEB + 2) tick();
    check("deb_fault", 32'(o_fault[1]), 32'h1);
    fb = 8'h00; repeat (DEB + 1) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    check("deb_clear", 32'(o_fault[1]), 32'h0);

    // trip on A,B,C feedback; clear only once the set is legal again
    do_reset();
    fb = 8'h07; repeat (DEB + 2) tick();
    check("trip_set", 32'(o_trip), 32'h1);
    check("trip_close", 32'(o_close), 32'h0);
    clr = 1'b1; repeat (2) tick();
    check("trip_hold", 32'(o_trip), 32'h1);
    fb = 8'h03;
    n = 0;
    while (o_trip && n < 20) begin tick(); n++; end
    check("trip_clear_lat", 32'(n), 32'(DEB + 1));
    clr = 1'b0;

    // simultaneous permitted requests, then reset during CLOSING
    do_reset();
    req = 8'h30;
    tick(); check("sim_ch4", 32'(o_close), 32'h10);
    tick(); check("sim_ch5", 32'(o_close), 32'h30);
    rst_n = 1'b0;
    tick(); check("sim_rst_drop", 32'(o_close), 32'h0);
    rst_n = 1'b1;

    // random traffic; feedback loosely follows the modelled coil command
    req = '0; fb = '0;
    for (int t = 0; t < 4000; t++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      clr   = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < N; i++) begin
        int r;
        if ($urandom_range(0, 9) == 0) req[i] = ~req[i];
        r = $urandom_range(0, 99);
        if (r < 30)      fb[i] = m_close[i];
        else if (r < 32) fb[i] = ~fb[i];
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
